// File: rtl/fifo_frame_writer_pkg.sv
// Shared types, constants and the header builder for the FIFO frame writer.
// With FRAME_CHECKSUM_EN defined the state set gains TRAILER for the XOR checksum word.
package fifo_frame_pkg;

  localparam int SEQ_W = 8;
  localparam int HDR_W = 12;
  localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} frame_state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} frame_state_t;
`endif

  function automatic logic [HDR_W-1:0] build_header(input logic [3:0] tag,
                                                    input logic [SEQ_W-1:0] seq);
    return {tag, seq};
  endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// Sample stream plus FIFO write-side bundle of the frame writer.
// master is the frame writer itself; slave is whoever drives samples and watches the FIFO side.
interface fifo_frame_writer_if #(parameter int DATASIZE = 12);

  logic                in_valid;
  logic [DATASIZE-1:0] in_data;
  logic                in_ready;
  logic                write_full;
  logic                write_enable;
  logic [DATASIZE-1:0] write_data;
  logic                frame_done;
  logic                busy;

  modport master (
    input  in_valid, in_data, write_full,
    output in_ready, write_enable, write_data, frame_done, busy
  );

  modport slave (
    output in_valid, in_data, write_full,
    input  in_ready, write_enable, write_data, frame_done, busy
  );

endinterface

// File: rtl/fifo_frame_writer_skid_buf.sv
// Two-entry valid/ready skid buffer feeding the frame writer; in_ready depends on registered state only.
// entry0 is always the oldest held sample.
module frame_skid_buf #(
  parameter int DATASIZE = 12
) (
  input  logic                write_clk,
  input  logic                read_reset_n,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_pop
);

  logic [DATASIZE-1:0] entry0;
  logic [DATASIZE-1:0] entry1;
  logic [1:0]          count;
  logic                alive;
  logic                push;
  logic                pop;

  // alive keeps in_ready low while reset is held and for the edge that releases it
  assign in_ready  = alive & (count != 2'd2);
  assign push      = in_valid & in_ready;
  assign pop       = out_pop & (count != 2'd0);
  assign out_valid = (count != 2'd0);
  assign out_data  = entry0;

  always_ff @(posedge write_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= in_data;
          else               entry1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= in_data;
          end else begin
            entry0 <= entry1;
            entry1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_frame_writer.sv
// Groups 12-bit samples into header + FRAME_LEN payload frames for the async FIFO write side.
// Optional FRAME_CHECKSUM_EN appends an XOR trailer word to every frame.
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int         DATASIZE  = 12,
  parameter int         FRAME_LEN = 16,
  parameter logic [3:0] HDR_TAG   = HDR_TAG_DEFAULT
) (
  input  logic                 write_clk,
  input  logic                 read_reset_n,
  fifo_frame_writer_if.master  bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  frame_state_t        state;
  logic [SEQ_W-1:0]    seq;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                out_valid;
  logic                out_last;
  logic [DATASIZE-1:0] out_word;
  logic                skid_valid;
  logic [DATASIZE-1:0] skid_data;
  logic                load_ok;
  logic                payload_pop;
`ifdef FRAME_CHECKSUM_EN
  logic [DATASIZE-1:0] csum;
`endif

  frame_skid_buf #(.DATASIZE(DATASIZE)) u_skid (
    .write_clk    (write_clk),
    .read_reset_n (read_reset_n),
    .in_valid     (bus.in_valid),
    .in_data      (bus.in_data),
    .in_ready     (bus.in_ready),
    .out_valid    (skid_valid),
    .out_data     (skid_data),
    .out_pop      (payload_pop)
  );

  // The output register may reload when empty or when its word leaves this cycle
  always_comb begin
    load_ok     = ~out_valid | ~bus.write_full;
    payload_pop = load_ok & skid_valid & ((state == HEADER) | (state == PAYLOAD));
    cnt_inc     = cnt + 1'b1;
  end

  assign bus.write_enable = out_valid & ~bus.write_full;
  assign bus.write_data   = out_word;
  assign bus.frame_done   = bus.write_enable & out_last;
  assign bus.busy         = (state != IDLE) | out_valid | skid_valid;

  always_ff @(posedge write_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      state     <= IDLE;
      seq       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_word  <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (load_ok) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (load_ok && skid_valid) begin
            out_valid <= 1'b1;
            out_word  <= DATASIZE'(build_header(HDR_TAG, seq));
            state     <= HEADER;
`ifdef FRAME_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        HEADER, PAYLOAD: begin
          if (payload_pop) begin
            out_valid <= 1'b1;
            out_word  <= skid_data;
`ifdef FRAME_CHECKSUM_EN
            csum      <= csum ^ skid_data;
`endif
            if (cnt_inc == LAST_CNT) begin
              cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
              state    <= TRAILER;
`else
              state    <= IDLE;
              seq      <= seq + 1'b1;
              out_last <= 1'b1;
`endif
            end else begin
              cnt   <= cnt_inc;
              state <= PAYLOAD;
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        TRAILER: begin
          if (load_ok) begin
            out_valid <= 1'b1;
            out_word  <= csum;
            out_last  <= 1'b1;
            seq       <= seq + 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
